// File: rtl/layer1_weight_arbiter_pkg.sv
// Shared types and sizing for the Layer 1 weight-storage arbiter.
// The row width comes from the global network sizing macros. Fallback values
// are provided so the block still elaborates when it is built on its own.
`ifndef RELU_NODES
`define RELU_NODES 4
`endif
`ifndef LAYER_1_BIT_WIDTH
`define LAYER_1_BIT_WIDTH 8
`endif

package layer1_weight_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = `RELU_NODES * `LAYER_1_BIT_WIDTH;

    // IDLE: writes allowed. FRAME: reads only. FLUSH: drain one held write.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_FLUSH = 2'd2
    } arbState_e;

endpackage

// File: rtl/layer1_weight_arbiter_hold.sv
// weight_write_hold: a one-entry holding register for loader writes.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   wr_req/wr_is_bias/wr_addr/wr_data - loader write request and payload
//   commit          - the arbiter is writing the held entry to storage this cycle
//   wr_ack          - payload captured this cycle
//   wr_busy         - entry occupied and not draining this cycle
//   full, holdAddr, holdData, holdBias - the held entry
module weight_write_hold
    import layer1_weight_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic              wr_is_bias,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    output logic              wr_ack,
    output logic              wr_busy,
    output logic              full,
    output logic [ADDR_W-1:0] holdAddr,
    output logic [DATA_W-1:0] holdData,
    output logic              holdBias
);

    // A committing entry frees the slot in the same cycle, so a new capture
    // can overlap the commit and streaming writes run at one per cycle.
    assign wr_ack  = wr_req && (!full || commit);
    assign wr_busy = full && !commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full     <= 1'b0;
            holdAddr <= '0;
            holdData <= '0;
            holdBias <= 1'b0;
        end else begin
            if (wr_ack) begin
                full     <= 1'b1;
                holdAddr <= wr_addr;
                holdData <= wr_data;
                holdBias <= wr_is_bias;
            end else if (commit) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/layer1_weight_arbiter.sv
// layer1_weight_arbiter: owns the single Layer 1 weight-storage port and
// shares it between the host loader (writes) and the compute sequencer (reads),
// keeping weights frozen while a frame is being accumulated.
// Ports:
//   clk, reset                      - clock, asynchronous active-low reset
//   frame_start, frame_done         - frame boundary pulses from compute
//   rd_req, rd_addr, rd_ack         - compute read request / accept
//   rd_valid, rd_data               - registered read response (next cycle)
//   wr_req, wr_is_bias, wr_addr, wr_data, wr_ack, wr_busy - loader write side
//   mem_addr, mem_wdata, mem_weight_we, mem_bias_we, mem_rdata - storage port
//   frame_active, frame_reads, protocol_err - status
module layer1_weight_arbiter
    import layer1_weight_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              frame_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic              wr_is_bias,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_weight_we,
    output logic              mem_bias_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              frame_active,
    output logic [ADDR_W:0]   frame_reads,
    output logic              protocol_err
);

    localparam logic [ADDR_W:0] READS_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] READS_ONE = (ADDR_W+1)'(1);

    arbState_e         state;
    logic              inFrame;
    logic              commit;
    logic              holdFull;
    logic              holdBias;
    logic [ADDR_W-1:0] holdAddr;
    logic [DATA_W-1:0] holdData;
    logic              protoViol;

    assign inFrame = (state == ST_FRAME);
    // Storage is written whenever the port is not reserved for reads.
    assign commit  = holdFull && !inFrame;

    weight_write_hold #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uHold (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_is_bias (wr_is_bias),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .wr_ack     (wr_ack),
        .wr_busy    (wr_busy),
        .full       (holdFull),
        .holdAddr   (holdAddr),
        .holdData   (holdData),
        .holdBias   (holdBias)
    );

    assign rd_ack        = inFrame && rd_req;
    assign mem_wdata     = commit ? holdData : '0;
    assign mem_weight_we = commit && !holdBias;
    assign mem_bias_we   = commit && holdBias;
    assign frame_active  = inFrame;

    always_comb begin
        mem_addr = '0;
        if (inFrame)     mem_addr = rd_addr;
        else if (commit) mem_addr = holdAddr;
    end

    assign protoViol = (rd_req && !inFrame)
                    || (frame_start && state != ST_IDLE)
                    || (frame_done && !inFrame);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            frame_reads  <= '0;
            protocol_err <= 1'b0;
        end else begin
            rd_valid <= rd_ack;
            if (rd_ack) begin
                rd_data <= mem_rdata;
                if (frame_reads != READS_MAX) frame_reads <= frame_reads + READS_ONE;
            end
            // A fresh frame always restarts the count, even over a same-cycle read.
            if (frame_start) frame_reads <= '0;
            if (protoViol)   protocol_err <= 1'b1;

            unique case (state)
                ST_IDLE:  if (frame_start) state <= ST_FRAME;
                ST_FRAME: if (frame_done)  state <= holdFull ? ST_FLUSH : ST_IDLE;
                ST_FLUSH: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
